// File: rtl/rv_multicycle_core.sv
// Four-state multicycle RV32I/E integer core (R-type and OP-IMM only, ECALL halts).
// Optional retired-instruction counter enabled by defining RV_CORE_RETIRE_CNT_EN.
module rv_multicycle_core #(
  parameter int              NREG     = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic [31:0]     IMEM_INST,
  input  logic            IMEM_VALID,
  output logic [31:0]     OUT,
  output logic            HALTED,
  output logic            TRAP,
  output logic [31:0]     RETIRED
);

  localparam int RW = $clog2(NREG);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [6:0]  OP_R  = 7'b0110011;
  localparam logic [6:0]  OP_I  = 7'b0010011;
  localparam logic [6:0]  F7_Z  = 7'b0000000;
  localparam logic [6:0]  F7_A  = 7'b0100000;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir, a, b, result, out_q;
  logic            trap_q, halted_q;
  logic [31:0]     regs [NREG];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic        illegal;
  logic [31:0] rd_a, rd_b;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R: illegal = !(funct7 == F7_Z ||
                        (funct7 == F7_A && (funct3 == 3'b000 || funct3 == 3'b101))) ||
                      (32'(rs2) >= NREG);
      OP_I: begin
        if (funct3 == 3'b001)      illegal = (funct7 != F7_Z);
        else if (funct3 == 3'b101) illegal = !(funct7 == F7_Z || funct7 == F7_A);
      end
      default: illegal = 1'b1;
    endcase
    if (32'(rd) >= NREG || 32'(rs1) >= NREG) illegal = 1'b1;
  end

  assign rd_a = (rs1 == 5'd0) ? 32'd0 : regs[rs1[RW-1:0]];
  assign rd_b = (rs2 == 5'd0) ? 32'd0 : regs[rs2[RW-1:0]];

  logic        is_r, alt;
  logic [31:0] imm, op2, alu;
  logic [4:0]  shamt;

  always_comb begin
    is_r  = ir[5];
    alt   = ir[30];
    imm   = {{20{ir[31]}}, ir[31:20]};
    op2   = is_r ? b : imm;
    shamt = op2[4:0];
    case (funct3)
      3'b000:  alu = (is_r && alt) ? a - op2 : a + op2;
      3'b001:  alu = a << shamt;
      3'b010:  alu = {31'd0, $signed(a) < $signed(op2)};
      3'b011:  alu = {31'd0, a < op2};
      3'b100:  alu = a ^ op2;
      3'b101:  alu = alt ? 32'($signed(a) >>> shamt) : a >> shamt;
      3'b110:  alu = a | op2;
      default: alu = a & op2;
    endcase
  end

`ifdef RV_CORE_RETIRE_CNT_EN
  logic [31:0] retired_q;
  always_ff @(posedge CLK) begin
    if (!RST)               retired_q <= '0;
    else if (state == S_WB) retired_q <= retired_q + 32'd1;
  end
  assign RETIRED = retired_q;
`else
  assign RETIRED = '0;
`endif

  // NOTE: the register file is cleared by reset along with all other state, so it is written
  // with a loop inside the clocked block rather than left to power-up contents.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      result   <= '0;
      out_q    <= '0;
      trap_q   <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (IMEM_VALID) begin
          ir    <= IMEM_INST;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a <= rd_a;
          b <= rd_b;
          // ECALL is tested first: its SYSTEM opcode would otherwise decode as illegal.
          if (ir == ECALL) begin
            halted_q <= 1'b1;
            state    <= S_STOP;
          end else if (illegal) begin
            trap_q <= 1'b1;
            state  <= S_STOP;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          result <= alu;
          state  <= S_WB;
        end
        S_WB: begin
          if (rd != 5'd0) begin
            regs[rd[RW-1:0]] <= result;
            out_q            <= result;
          end
          pc    <= pc + PC_W'(4);
          state <= S_FETCH;
        end
        default: state <= S_STOP;
      endcase
    end
  end

  assign IMEM_ADDR = pc;
  assign OUT       = out_q;
  assign TRAP      = trap_q;
  assign HALTED    = halted_q;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Self-checking bench: directed ISA cases plus random R/I instructions against an ISA-level model;
// a second instance (NREG=16, PC_W=8, RESET_PC=0xFC) covers register range, PC wrap and reset abort.
module tb_rv_multicycle_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_INST = '0;
  logic        IMEM_VALID = 1'b0;
  logic [31:0] OUT;
  logic        HALTED, TRAP;
  logic [31:0] RETIRED;

  logic        s_rst = 1'b0;
  logic [7:0]  s_addr;
  logic [31:0] s_inst = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_out;
  logic        s_halted, s_trap;
  logic [31:0] s_retired;

  int total = 0;
  int bad   = 0;

  rv_multicycle_core dut (
    .CLK(CLK), .RST(RST), .IMEM_ADDR(IMEM_ADDR), .IMEM_INST(IMEM_INST), .IMEM_VALID(IMEM_VALID),
    .OUT(OUT), .HALTED(HALTED), .TRAP(TRAP), .RETIRED(RETIRED)
  );

  rv_multicycle_core #(.NREG(16), .PC_W(8), .RESET_PC(8'hFC)) dut_s (
    .CLK(CLK), .RST(s_rst), .IMEM_ADDR(s_addr), .IMEM_INST(s_inst), .IMEM_VALID(s_valid),
    .OUT(s_out), .HALTED(s_halted), .TRAP(s_trap), .RETIRED(s_retired)
  );

  always #5 CLK = ~CLK;

  // Architectural model of the main instance
  logic [31:0] mdl [32];
  logic [31:0] m_out, m_pc, m_ret;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_retired(input logic [31:0] n);
`ifdef RV_CORE_RETIRE_CNT_EN
    return n;
`else
    return (n & 32'd0);
`endif
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // ISA semantics: operand fetch, then the mnemonic's arithmetic
  function automatic logic [31:0] ref_result(input logic [31:0] inst);
    logic        r;
    logic [31:0] x, y, fill;
    logic [4:0]  sh;
    r  = (inst[6:0] == 7'b0110011);
    x  = mdl[inst[19:15]];
    y  = r ? mdl[inst[24:20]] : {{20{inst[31]}}, inst[31:20]};
    sh = y[4:0];
    case (inst[14:12])
      3'd0: return (r && inst[30]) ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: begin
        fill = (inst[30] && x[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        return (x >> sh) | fill;
      end
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [31:0] gen_rand();
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  f7;
    logic [11:0] imm;
    f3  = 3'($urandom);
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    if ($urandom_range(1) == 1) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(1) == 1) ? 7'b0100000 : 7'b0000000;
      return enc_r(f7, rs2, rs1, f3, rd);
    end
    imm = 12'($urandom);
    if (f3 == 3'd1)      imm[11:5] = 7'b0000000;
    else if (f3 == 3'd5) imm[11:5] = ($urandom_range(1) == 1) ? 7'b0100000 : 7'b0000000;
    return enc_i(imm, rs1, f3, rd);
  endfunction

  task automatic do_reset();
    RST        = 1'b0;
    IMEM_VALID = 1'b1;
    IMEM_INST  = enc_i(12'd1, 5'd0, 3'd0, 5'd1);
    step();
    step();
    RST        = 1'b1;
    IMEM_VALID = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    m_out = '0;
    m_pc  = '0;
    m_ret = '0;
    check("rst_out", OUT, 32'd0);
    check("rst_addr", IMEM_ADDR, 32'd0);
    check("rst_trap", {31'd0, TRAP}, 32'd0);
    check("rst_halted", {31'd0, HALTED}, 32'd0);
    check("rst_retired", RETIRED, 32'd0);
  endtask

  task automatic run_inst(input logic [31:0] inst, input int stall);
    logic [31:0] res, prev;
    prev       = m_out;
    res        = ref_result(inst);
    IMEM_VALID = 1'b0;
    IMEM_INST  = $urandom;
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_addr", IMEM_ADDR, m_pc);
    end
    IMEM_INST  = inst;
    IMEM_VALID = 1'b1;
    step();
    IMEM_INST  = $urandom;
    IMEM_VALID = 1'($urandom_range(1));
    step();
    step();
    check("pre_wb_out", OUT, prev);
    step();
    if (inst[11:7] != 5'd0) begin
      mdl[inst[11:7]] = res;
      m_out           = res;
    end
    m_pc  = m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    check("out", OUT, m_out);
    check("addr", IMEM_ADDR, m_pc);
    check("retired", RETIRED, exp_retired(m_ret));
    IMEM_VALID = 1'b0;
  endtask

  // Feed an instruction that must end in STOP; then confirm later inputs are ignored.
  task automatic run_stop(input logic [31:0] inst, input logic exp_trap, input logic exp_halt);
    IMEM_INST  = inst;
    IMEM_VALID = 1'b1;
    step();
    step();
    check("stop_trap", {31'd0, TRAP}, {31'd0, exp_trap});
    check("stop_halted", {31'd0, HALTED}, {31'd0, exp_halt});
    for (int i = 0; i < 6; i++) begin
      IMEM_INST = enc_i(12'($urandom), 5'd0, 3'd0, 5'd9);
      step();
    end
    check("stop_out", OUT, m_out);
    check("stop_addr", IMEM_ADDR, m_pc);
    check("stop_retired", RETIRED, exp_retired(m_ret));
    check("stop_trap_held", {31'd0, TRAP}, {31'd0, exp_trap});
    IMEM_VALID = 1'b0;
  endtask

  task automatic s_run4(input logic [31:0] inst);
    s_inst  = inst;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    do_reset();

    run_inst(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 0);
    check("addi_5", OUT, 32'd5);
    run_inst(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 0);
    check("addi_m3", OUT, 32'hFFFF_FFFD);
    check("addr_8", IMEM_ADDR, 32'd8);

    run_inst(enc_r(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3), 0);
    check("sub", OUT, 32'd8);
    run_inst(enc_r(7'b0000000, 5'd1, 5'd2, 3'd2, 5'd4), 0);
    check("slt", OUT, 32'd1);
    run_inst(enc_r(7'b0000000, 5'd1, 5'd2, 3'd3, 5'd5), 0);
    check("sltu", OUT, 32'd0);
    run_inst(enc_r(7'b0100000, 5'd1, 5'd2, 3'd5, 5'd6), 0);
    check("sra", OUT, 32'hFFFF_FFFF);

    run_inst(enc_i(12'd1, 5'd1, 3'd0, 5'd7), 3);
    check("stall_out", OUT, 32'd6);
    run_inst(enc_i(12'd9, 5'd1, 3'd0, 5'd0), 0);
    check("rd0_out", OUT, 32'd6);

    for (int n = 0; n < 40; n++) run_inst(gen_rand(), int'($urandom_range(2)));

    run_stop(enc_r(7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1, 1'b0);
    do_reset();
    run_inst(enc_i(12'd4, 5'd0, 3'd0, 5'd1), 0);
    run_stop(enc_i(12'h403, 5'd1, 3'd1, 5'd4), 1'b1, 1'b0);

    do_reset();
    run_inst(enc_i(12'd1, 5'd0, 3'd0, 5'd1), 0);
    run_inst(enc_i(12'd2, 5'd1, 3'd0, 5'd2), 1);
    run_inst(enc_i(12'd3, 5'd2, 3'd0, 5'd3), 0);
    check("pre_ecall_out", OUT, 32'd6);
    run_stop(32'h0000_0073, 1'b0, 1'b1);
    check("ecall_retired", RETIRED, exp_retired(32'd3));

    // Second instance: 8-bit PC wrap, reset mid-instruction, RV32E register range
    s_rst = 1'b0;
    step();
    step();
    s_rst = 1'b1;
    check("s_rst_addr", {24'd0, s_addr}, 32'h0000_00FC);
    s_run4(enc_i(12'd7, 5'd0, 3'd0, 5'd1));
    check("s_out_7", s_out, 32'd7);
    check("s_wrap", {24'd0, s_addr}, 32'd0);
    check("s_retired", s_retired, exp_retired(32'd1));

    s_inst  = enc_i(12'd9, 5'd0, 3'd0, 5'd2);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    s_rst = 1'b0;
    step();
    s_rst = 1'b1;
    check("s_abort_addr", {24'd0, s_addr}, 32'h0000_00FC);
    check("s_abort_out", s_out, 32'd0);
    check("s_abort_retired", s_retired, 32'd0);
    s_run4(enc_i(12'd1, 5'd2, 3'd0, 5'd3));
    check("s_x2_clear", s_out, 32'd1);

    s_inst  = enc_r(7'b0000000, 5'd2, 5'd1, 3'd0, 5'd17);
    s_valid = 1'b1;
    step();
    step();
    check("s_trap", {31'd0, s_trap}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      s_inst = enc_i(12'($urandom), 5'd0, 3'd0, 5'd4);
      step();
    end
    check("s_trap_out", s_out, 32'd1);
    check("s_trap_addr", {24'd0, s_addr}, 32'd0);
    check("s_trap_held", {31'd0, s_trap}, 32'd1);
    s_valid = 1'b0;
    s_rst   = 1'b0;
    step();
    s_rst = 1'b1;
    check("s_trap_clear", {31'd0, s_trap}, 32'd0);
    check("s_clear_addr", {24'd0, s_addr}, 32'h0000_00FC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_core.md
RV_MULTICYCLE_CORE -- requirements
Module: rv_multicycle_core

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of architectural registers; legal values 16 (RV32E) or 32.
REQ-002 SHALL have parameter PC_W, default 32, meaning program-counter and IMEM_ADDR width (8..32).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded at reset.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset; synchronous, active-low.
REQ-006 IMEM_ADDR  output  PC_W  byte address of instruction being fetched (equals PC).
REQ-007 IMEM_INST  input  32  instruction word at IMEM_ADDR.
REQ-008 IMEM_VALID  input  1  IMEM_INST valid this cycle.
REQ-009 OUT  output  32  last value written to a nonzero rd.
REQ-010 HALTED  output  1  core stopped after ECALL (0x00000073).
REQ-011 TRAP  output  1  core stopped on illegal instruction.
REQ-012 RETIRED  output  32  retired-instruction count (see Configuration).

Function
REQ-013 SHALL run a four-state FSM: FETCH -> DECODE -> EXEC -> WB -> FETCH, plus terminal STOP.
REQ-014 FETCH: SHALL hold IMEM_ADDR = PC; on the first edge with IMEM_VALID=1, SHALL latch IMEM_INST into IR and go to DECODE; with IMEM_VALID=0, SHALL remain in FETCH indefinitely.
REQ-015 DECODE: SHALL latch A = x[rs1] and B = x[rs2] (rs1 = IR[19:15], rs2 = IR[24:20]), with x0 reading 0; SHALL flag illegal on unsupported opcode/funct, or any rs1/rs2/rd >= NREG.
REQ-016 Supported R-type (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; funct7 SHALL be 0000000, or 0100000 for SUB/SRA only; all other funct7 values are illegal.
REQ-017 Supported I-type (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; imm = sign-extended IR[31:20]; shifts use IR[24:20], and IR[31:25] SHALL be 0000000, or 0100000 for SRAI only.
REQ-018 EXEC: SHALL compute a 32-bit result, with sum/difference modulo 2^32; shift amount = operand[4:0]; SRA/SRAI replicate bit 31; SLT signed, SLTU unsigned, result 0 or 1.
REQ-019 WB: SHALL write result to x[rd] if rd != 0, and set OUT = result; if rd = 0, both the register file and OUT are unchanged.
REQ-020 WB: SHALL set PC = (PC + 4) mod 2^PC_W (wrap to 0 permitted) and return to FETCH.
REQ-021 Instruction latency SHALL be 4 cycles with IMEM_VALID held high, i.e. one retirement per 4 edges.
REQ-022 Illegal instruction: from DECODE, SHALL go to STOP with TRAP=1, no register write, PC unchanged.
REQ-023 ECALL: from DECODE, SHALL go to STOP with HALTED=1, no register write, PC unchanged; ECALL SHALL NOT count as retired.
REQ-024 STOP SHALL be left only by reset; IMEM_ADDR SHALL hold PC while in STOP.
REQ-025 The register file SHALL be internal, NREG x 32 bits, one write port (WB only).

Reset
REQ-026 On a rising edge with RST=0: PC = RESET_PC, state = FETCH, all registers = 0, IR/A/B/result = 0, OUT = 0, TRAP = 0, HALTED = 0, RETIRED = 0.
REQ-027 Reset asserted in any state, including mid-instruction, SHALL abort that instruction with no register write and no count increment.
REQ-028 While RST=0, the core SHALL perform no fetch-latch and no write.

Configuration
REQ-029 With RV_CORE_RETIRE_CNT_EN defined: RETIRED SHALL increment by 1 (mod 2^32) on each WB edge, including writes to rd=0.
REQ-030 Without RV_CORE_RETIRE_CNT_EN: RETIRED SHALL be constant 0, and no counter register SHALL exist.

Verification
REQ-031 Reset, then ADDI x1,x0,5 and ADDI x2,x0,-3 with IMEM_VALID=1 -> OUT=5 after edge 4, OUT=0xFFFFFFFD after edge 8, IMEM_ADDR=8.
REQ-032 With x1=5, x2=-3: SUB x3,x1,x2 -> OUT=8; SLT x4,x2,x1 -> 1; SLTU x5,x2,x1 -> 0; SRA x6,x2,x1 (shift 5) -> 0xFFFFFFFF.
REQ-033 IMEM_VALID=0 for 3 cycles during FETCH, then 1 -> instruction retires 7 edges after fetch start; IMEM_ADDR stable throughout.
REQ-034 NREG=16: ADD x17,x1,x2 -> TRAP=1, OUT unchanged, PC unchanged; later inputs ignored until RST=0 clears TRAP.
REQ-035 ECALL after 3 retired ADDIs with RV_CORE_RETIRE_CNT_EN -> HALTED=1, RETIRED=3; RETIRED=0 with the macro undefined.
REQ-036 PC_W=8, RESET_PC=0xFC: one ADDI retires -> IMEM_ADDR wraps to 0x00; RST=0 asserted in EXEC of the next instruction -> that write is absent, PC=0xFC.
